// File: rtl/cnt120_dn.sv
// Modulo-MODULUS down-counter with asynchronous master reset, active-low clamped
// parallel load, CET-gated terminal count on zero, a one-cycle wrap pulse and a sticky underflow flag.
module cnt120_dn #(
   parameter int WIDTH   = 8,
   parameter int MODULUS = 120
) (
   input  logic             Clk,
   input  logic             MR,
   input  logic             CEP,
   input  logic             CET,
   input  logic             PE,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             WRP,
   output logic             UFL
);

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_LOAD,
      OP_COUNT
   } op_t;

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   op_t  op;
   logic q_zero;

   // Out-of-range load data saturates to the top count so Q never leaves 0..MODULUS-1.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
      if (int'(d) >= MODULUS) return MAX_Q;
      return d;
   endfunction

   always_comb begin
      op = OP_HOLD;
      if (!PE)
         op = OP_LOAD;
      else if (CEP && CET)
         op = OP_COUNT;
   end

   assign q_zero = (Q == '0);
   assign TC     = CET & q_zero;

   // Registered count, wrap pulse and sticky underflow.
   always_ff @(posedge Clk or posedge MR) begin
      if (MR) begin
         Q   <= '0;
         WRP <= 1'b0;
         UFL <= 1'b0;
      end else begin
         case (op)
            OP_LOAD: begin
               Q   <= clamp_load(D);
               WRP <= 1'b0;
               UFL <= 1'b0;
            end
            OP_COUNT: begin
               if (q_zero) begin
                  Q   <= MAX_Q;
                  WRP <= 1'b1;
                  UFL <= 1'b1;
               end else begin
                  Q   <= Q - WIDTH'(1);
                  WRP <= 1'b0;
               end
            end
            default: begin
               WRP <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnt120_dn.sv
// Directed bench for cnt120_dn: a vector table for load/count/gating plus
// hand-written sequences for reset, reset-during-wrap and a two-stage cascade.
module tb_cnt120_dn;

   logic       Clk;
   logic       MR, CEP, CET, PE;
   logic [7:0] D, Q;
   logic       TC, WRP, UFL;

   logic       cCEP, cPE;
   logic [7:0] dLo, dHi, qLo, qHi;
   logic       tcLo, tcHi, wrpLo, wrpHi, uflLo, uflHi;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic       pe, cep, cet;
      logic [7:0] d;
      logic [7:0] q;
      logic       tc, wrp, ufl;
   } vec_t;

   vec_t vecs[16];

   cnt120_dn #(.WIDTH(8), .MODULUS(120)) dut (
      .Clk(Clk), .MR(MR), .CEP(CEP), .CET(CET), .PE(PE), .D(D),
      .Q(Q), .TC(TC), .WRP(WRP), .UFL(UFL)
   );

   cnt120_dn #(.WIDTH(8), .MODULUS(120)) u_lo (
      .Clk(Clk), .MR(MR), .CEP(cCEP), .CET(1'b1), .PE(cPE), .D(dLo),
      .Q(qLo), .TC(tcLo), .WRP(wrpLo), .UFL(uflLo)
   );

   cnt120_dn #(.WIDTH(8), .MODULUS(120)) u_hi (
      .Clk(Clk), .MR(MR), .CEP(cCEP), .CET(tcLo), .PE(cPE), .D(dHi),
      .Q(qHi), .TC(tcHi), .WRP(wrpHi), .UFL(uflHi)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_v(int i, logic pe, logic cep, logic cet, logic [7:0] d,
                        logic [7:0] q, logic tc, logic wrp, logic ufl);
      vecs[i].pe = pe;  vecs[i].cep = cep; vecs[i].cet = cet; vecs[i].d = d;
      vecs[i].q = q;    vecs[i].tc = tc;   vecs[i].wrp = wrp; vecs[i].ufl = ufl;
   endtask

   initial begin
      //      pe cep cet  d     q   tc wrp ufl
      set_v( 0, 0, 1, 1,  45,  45,  0, 0, 0);
      set_v( 1, 0, 1, 1, 200, 119,  0, 0, 0);
      set_v( 2, 0, 1, 1, 119, 119,  0, 0, 0);
      set_v( 3, 0, 1, 1,   3,   3,  0, 0, 0);
      set_v( 4, 1, 1, 1,   0,   2,  0, 0, 0);
      set_v( 5, 1, 1, 1,   0,   1,  0, 0, 0);
      set_v( 6, 1, 1, 1,   0,   0,  1, 0, 0);
      set_v( 7, 1, 1, 1,   0, 119,  0, 1, 1);
      set_v( 8, 1, 1, 1,   0, 118,  0, 0, 1);
      set_v( 9, 0, 1, 1,  10,  10,  0, 0, 0);
      set_v(10, 1, 0, 1,   0,  10,  0, 0, 0);
      set_v(11, 1, 0, 1,   0,  10,  0, 0, 0);
      set_v(12, 1, 0, 1,   0,  10,  0, 0, 0);
      set_v(13, 0, 1, 1,   0,   0,  1, 0, 0);
      set_v(14, 1, 1, 0,   0,   0,  0, 0, 0);
      set_v(15, 0, 1, 1,  77,  77,  0, 0, 0);

      MR = 1'b1; PE = 1'b1; CEP = 1'b0; CET = 1'b1; D = 8'd0;
      cCEP = 1'b0; cPE = 1'b1; dLo = 8'd0; dHi = 8'd0;
      tick();
      tick();
      check("reset_q", Q, 0);
      check("reset_wrp", WRP, 0);
      check("reset_ufl", UFL, 0);
      check("reset_tc_cet1", TC, 1);
      MR = 1'b0;

      for (int i = 0; i < 16; i++) begin
         PE = vecs[i].pe; CEP = vecs[i].cep; CET = vecs[i].cet; D = vecs[i].d;
         tick();
         check($sformatf("vec%0d_q", i), Q, vecs[i].q);
         check($sformatf("vec%0d_tc", i), TC, vecs[i].tc);
         check($sformatf("vec%0d_wrp", i), WRP, vecs[i].wrp);
         check($sformatf("vec%0d_ufl", i), UFL, vecs[i].ufl);
      end

      // Reach Q=57 with UFL set, then assert MR mid-cycle.
      PE = 1'b0; D = 8'd0; CEP = 1'b1; CET = 1'b1;
      tick();
      PE = 1'b1;
      tick();
      repeat (62) tick();
      check("pre_reset_q", Q, 57);
      check("pre_reset_ufl", UFL, 1);
      #2 MR = 1'b1;
      #1;
      check("async_reset_q", Q, 0);
      check("async_reset_ufl", UFL, 0);
      check("async_reset_wrp", WRP, 0);
      check("async_reset_tc_cet1", TC, 1);
      CET = 1'b0;
      #1;
      check("async_reset_tc_cet0", TC, 0);
      CET = 1'b1;
      @(negedge Clk);
      MR = 1'b0;
      tick();
      check("post_reset_wrap_q", Q, 119);
      check("post_reset_wrap_wrp", WRP, 1);
      check("post_reset_wrap_ufl", UFL, 1);
      tick();
      check("post_reset_next_q", Q, 118);
      check("post_reset_next_wrp", WRP, 0);

      // MR coincident with the 0 -> 119 edge.
      PE = 1'b0; D = 8'd0;
      tick();
      PE = 1'b1;
      check("wrap_reset_pre_tc", TC, 1);
      @(posedge Clk);
      MR = 1'b1;
      #1;
      check("wrap_reset_q", Q, 0);
      check("wrap_reset_wrp", WRP, 0);
      check("wrap_reset_ufl", UFL, 0);
      @(negedge Clk);
      MR = 1'b0;

      // Two-stage cascade: lower=1, upper=2.
      cPE = 1'b0; dLo = 8'd1; dHi = 8'd2; cCEP = 1'b0;
      tick();
      check("casc_load_hi", qHi, 2);
      check("casc_load_lo", qLo, 1);
      cPE = 1'b1; cCEP = 1'b1;
      tick();
      check("casc_e1_hi", qHi, 2);
      check("casc_e1_lo", qLo, 0);
      tick();
      check("casc_e2_hi", qHi, 1);
      check("casc_e2_lo", qLo, 119);
      tick();
      check("casc_e3_hi", qHi, 1);
      check("casc_e3_lo", qLo, 118);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
